booth_controller: RTL and testbench

BOOTH_CONTROLLER -- requirements
Module: booth_controller

---
 rtl/booth_pkg.sv | 14 +
 rtl/booth_iter_counter.sv | 30 +++
 rtl/booth_controller.sv | 72 +++++++
 tb/tb_booth_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and defaults for the radix-2 Booth multiplier sequencer.
package booth_pkg;

   localparam int BOOTH_WIDTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EVAL,
      ST_SHIFT,
      ST_DONE
   } booth_state_t;

endpackage

// File: rtl/booth_iter_counter.sv
// Booth iteration counter: cleared on operand load, stepped once per shift,
// flags the final iteration.
module booth_iter_counter
   import booth_pkg::*;
#(
   parameter int WIDTH = BOOTH_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic last
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt;

   // Holds at the terminal value so a stray step can never wrap the count.
   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (inc && !last)
         cnt <= cnt + 1'b1;
   end

   assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/booth_controller.sv
// Control FSM for a radix-2 Booth multiplier datapath: sequences operand
// load, WIDTH evaluate/shift iterations and the result handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_LOAD  | datapath loads operands, clears A and Q-1
// ST_EVAL  | add or subtract M depending on {Q0,Q-1}
// ST_SHIFT | arithmetic right shift of {A,Q,Q-1}, one iteration done
// ST_DONE  | product valid, waiting for ready
module booth_controller
   import booth_pkg::*;
#(
   parameter int WIDTH = BOOTH_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic ready,
   input  logic q_lsb,
   input  logic q_m1,
   output logic load,
   output logic add_en,
   output logic sub_en,
   output logic shift_en,
   output logic busy,
   output logic valid_out
);

   localparam int CNT_W = $clog2(WIDTH);

   booth_state_t state;
   logic         iter_last;
   logic         in_eval;

   booth_iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk   (clk),
      .reset (reset),
      .clear (load),
      .inc   (shift_en),
      .last  (iter_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start) state <= ST_LOAD;
            ST_LOAD:  state <= ST_EVAL;
            ST_EVAL:  state <= ST_SHIFT;
            ST_SHIFT: state <= iter_last ? ST_DONE : ST_EVAL;
            ST_DONE:  if (ready) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign in_eval   = (state == ST_EVAL);
   assign load      = (state == ST_LOAD);
   assign shift_en  = (state == ST_SHIFT);
   assign valid_out = (state == ST_DONE);
   assign busy      = load | in_eval | shift_en;

   // Booth recoding: 10 starts a run of ones (subtract), 01 ends one (add).
   assign sub_en = in_eval &  q_lsb & ~q_m1;
   assign add_en = in_eval & ~q_lsb &  q_m1;

endmodule

// File: tb/tb_booth_controller.sv
// Self-checking bench for booth_controller: WIDTH=4 and WIDTH=8 instances
// driven in lockstep and compared every cycle against a cycle-offset model.
module tb_booth_controller;

   logic clk = 1'b0;
   logic reset, start, ready, q_lsb, q_m1;
   logic load4, add4, sub4, shift4, busy4, valid4;
   logic load8, add8, sub8, shift8, busy8, valid8;

   int total = 0;
   int bad   = 0;

   // Model: phase = cycles since start was accepted, -1 when idle.
   int         m_phase [2];
   int         m_w     [2] = '{4, 8};
   bit         m_known = 1'b0;
   logic [5:0] obs     [2];

   always #5 clk = ~clk;

   booth_controller #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .ready(ready),
      .q_lsb(q_lsb), .q_m1(q_m1),
      .load(load4), .add_en(add4), .sub_en(sub4), .shift_en(shift4),
      .busy(busy4), .valid_out(valid4)
   );

   booth_controller #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start), .ready(ready),
      .q_lsb(q_lsb), .q_m1(q_m1),
      .load(load8), .add_en(add8), .sub_en(sub8), .shift_en(shift8),
      .busy(busy8), .valid_out(valid8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Bit order {load, add_en, sub_en, shift_en, busy, valid_out}.
   function automatic logic [5:0] exp_out(int p, int w, logic ql, logic qm);
      int   lb;
      logic ev, sh;
      lb = 1 + 2 * w;
      ev = (p >= 2) && (p <= lb) && (p % 2 == 0);
      sh = (p >= 3) && (p <= lb) && (p % 2 == 1);
      return {p == 1, ev && !ql && qm, ev && ql && !qm, sh, (p >= 1) && (p <= lb), p > lb};
   endfunction

   // One cycle: compare outputs for the current inputs, clock, advance model.
   task automatic tick();
      #1;
      obs[0] = {load4, add4, sub4, shift4, busy4, valid4};
      obs[1] = {load8, add8, sub8, shift8, busy8, valid8};
      if (m_known) begin
         chk("out_w4", 32'(obs[0]), 32'(exp_out(m_phase[0], m_w[0], q_lsb, q_m1)));
         chk("out_w8", 32'(obs[1]), 32'(exp_out(m_phase[1], m_w[1], q_lsb, q_m1)));
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (reset)
            m_phase[i] = -1;
         else if (m_phase[i] < 0) begin
            if (start) m_phase[i] = 1;
         end else if (m_phase[i] <= 1 + 2 * m_w[i])
            m_phase[i]++;
         else if (ready)
            m_phase[i] = -1;
      end
      if (reset) m_known = 1'b1;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; ready = 1'b0; q_lsb = 1'b0; q_m1 = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int n_sh, n_busy, n_v, n_ld, first_v, ld_at;

      // Basic WIDTH=4 run with forced Booth pairs in the EVAL cycles.
      do_reset();
      ready = 1'b1;
      n_sh = 0; n_busy = 0; n_v = 0; first_v = -1; ld_at = -1;
      for (int c = 0; c < 14; c++) begin
         start = (c == 0);
         case (c)
            2:       {q_lsb, q_m1} = 2'b00;
            4:       {q_lsb, q_m1} = 2'b10;
            6:       {q_lsb, q_m1} = 2'b11;
            8:       {q_lsb, q_m1} = 2'b01;
            default: {q_lsb, q_m1} = 2'($urandom_range(0, 3));
         endcase
         tick();
         if (c == 0) chk("reset_state", 32'(obs[0]), 32'd0);
         if (obs[0][5] && ld_at < 0) ld_at = c;
         if (obs[0][0] && first_v < 0) first_v = c;
         n_sh   += int'(obs[0][2]);
         n_busy += int'(obs[0][1]);
         n_v    += int'(obs[0][0]);
         if (c == 2 || c == 6) chk("eval_none", 32'(obs[0][4:3]), 32'd0);
         if (c == 4) chk("eval_sub", 32'(obs[0][4:3]), 32'd1);
         if (c == 8) chk("eval_add", 32'(obs[0][4:3]), 32'd2);
      end
      chk("load_cycle", ld_at, 1);
      chk("shift_count", n_sh, 4);
      chk("busy_count", n_busy, 9);
      chk("valid_first", first_v, 10);
      chk("valid_count", n_v, 1);

      // start re-pulsed while busy must be ignored.
      do_reset();
      ready = 1'b1;
      n_sh = 0; n_ld = 0; first_v = -1;
      for (int c = 0; c < 14; c++) begin
         start = (c == 0 || c == 3 || c == 6);
         {q_lsb, q_m1} = 2'($urandom_range(0, 3));
         tick();
         n_sh += int'(obs[0][2]);
         n_ld += int'(obs[0][5]);
         if (obs[0][0] && first_v < 0) first_v = c;
      end
      chk("busy_start_shifts", n_sh, 4);
      chk("busy_start_loads", n_ld, 1);
      chk("busy_start_valid", first_v, 10);

      // Result held while ready is low.
      do_reset();
      n_v = 0;
      for (int c = 0; c < 20; c++) begin
         start = (c == 0);
         ready = (c >= 15);
         {q_lsb, q_m1} = 2'($urandom_range(0, 3));
         tick();
         if (c >= 10 && c <= 14) n_v += int'(obs[0][0]);
         if (c == 15) chk("valid_held", 32'(obs[0][0]), 32'd1);
         if (c == 16) chk("valid_drop", 32'(obs[0][1:0]), 32'd0);
      end
      chk("valid_hold_count", n_v, 5);

      // Reset mid-operation aborts; next start begins cleanly.
      do_reset();
      ready = 1'b1;
      first_v = -1;
      for (int c = 0; c < 20; c++) begin
         start = (c == 0 || c == 7);
         reset = (c == 5);
         {q_lsb, q_m1} = 2'($urandom_range(0, 3));
         tick();
         if (c == 6) chk("abort_out", 32'(obs[0]), 32'd0);
         if (obs[0][0] && first_v < 0) first_v = c;
      end
      reset = 1'b0;
      chk("abort_restart_valid", first_v, 17);

      // WIDTH=8: start+ready together in DONE only returns to IDLE.
      do_reset();
      first_v = -1; n_ld = 0; ld_at = -1;
      for (int c = 0; c < 44; c++) begin
         start = (c == 0 || c == 18 || c == 22);
         ready = (c == 18);
         {q_lsb, q_m1} = 2'($urandom_range(0, 3));
         tick();
         if (c <= 18 && obs[1][0] && first_v < 0) first_v = c;
         if (c == 18) chk("w8_valid_first", first_v, 18);
         if (c == 19) chk("w8_idle", 32'(obs[1]), 32'd0);
         if (c >= 19 && c <= 22) n_ld += int'(obs[1][5]);
         if (c == 23) chk("w8_reload", 32'(obs[1][5]), 32'd1);
         if (c == 22) first_v = -1;
         if (c > 22 && obs[1][0] && first_v < 0) first_v = c;
      end
      chk("w8_no_load", n_ld, 0);
      chk("w8_valid_second", first_v, 40);

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 49) == 0);
         start = ($urandom_range(0, 3) == 0);
         ready = 1'($urandom_range(0, 1));
         {q_lsb, q_m1} = 2'($urandom_range(0, 3));
         tick();
         chk("excl", 32'(obs[0][4] & obs[0][3]) | 32'(obs[1][4] & obs[1][3]), 32'd0);
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
